// File: rtl/os_sram_port_sched_pkg.sv
// Shared types and helpers for the corelet SRAM port scheduler:
// FSM states, requester encoding and round-robin selection.
package os_sram_port_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_BURST = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        REQ_NONE  = 2'b00,
        REQ_L0    = 2'b01,
        REQ_IFIFO = 2'b10,
        REQ_OFIFO = 2'b11
    } req_e;

    localparam int NUM_REQ = 3;

    // Bit 0 = L0, bit 1 = IFIFO, bit 2 = OFIFO.
    function automatic logic [NUM_REQ-1:0] req_to_oh(input req_e r);
        logic [NUM_REQ-1:0] oh;
        case (r)
            REQ_L0:    oh = 3'b001;
            REQ_IFIFO: oh = 3'b010;
            REQ_OFIFO: oh = 3'b100;
            default:   oh = 3'b000;
        endcase
        return oh;
    endfunction

    // First eligible requester after 'last' in L0->IFIFO->OFIFO order;
    // assignments run lowest priority first so the last match wins.
    function automatic req_e rr_pick(input logic [NUM_REQ-1:0] elig, input req_e last);
        req_e res;
        res = REQ_NONE;
        case (last)
            REQ_L0: begin
                if (elig[0]) res = REQ_L0;
                if (elig[2]) res = REQ_OFIFO;
                if (elig[1]) res = REQ_IFIFO;
            end
            REQ_IFIFO: begin
                if (elig[1]) res = REQ_IFIFO;
                if (elig[0]) res = REQ_L0;
                if (elig[2]) res = REQ_OFIFO;
            end
            default: begin
                if (elig[2]) res = REQ_OFIFO;
                if (elig[1]) res = REQ_IFIFO;
                if (elig[0]) res = REQ_L0;
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/os_sram_port_sched_arb.sv
// Three-way round-robin arbiter with OFIFO-full override, rotation pointer
// and per-grant burst length counter.
module os_sram_port_sched_arb
    import os_sram_port_sched_pkg::*;
#(
    parameter int burst_len = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] i_elig,
    input  logic               i_ofifo_full,
    input  logic               i_arb,
    input  logic               i_burst,
    input  req_e               i_cur,
    output req_e               o_grant,
    output logic               o_cont
);

    localparam int BC_W = $clog2(burst_len + 1);

    req_e            r_last;
    logic [BC_W-1:0] r_bcnt;
    logic            w_cur_elig;

    always_comb begin
        o_grant = REQ_NONE;
        if (i_arb) begin
            if (i_ofifo_full && i_elig[2]) begin
                o_grant = REQ_OFIFO;
            end else begin
                o_grant = rr_pick(i_elig, r_last);
            end
        end
    end

    assign w_cur_elig = |(req_to_oh(i_cur) & i_elig);
    assign o_cont     = i_burst && w_cur_elig && (r_bcnt < BC_W'(burst_len));

    // Pointer resets to OFIFO so the first grant after reset goes to L0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= REQ_OFIFO;
            r_bcnt <= '0;
        end else if (o_grant != REQ_NONE) begin
            r_last <= o_grant;
            r_bcnt <= BC_W'(1);
        end else if (o_cont) begin
            r_bcnt <= r_bcnt + BC_W'(1);
        end
    end

endmodule

// File: rtl/os_sram_port_sched.sv
// Corelet single-port SRAM scheduler: sequences one tile of L0 fills, IFIFO
// fills and OFIFO drains per start pulse; drives addresses and strobes only.
module os_sram_port_sched
    import os_sram_port_sched_pkg::*;
#(
    parameter int addr_width = 11,
    parameter int cnt_w      = 11,
    parameter int burst_len  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [addr_width-1:0] act_base_i,
    input  logic [addr_width-1:0] wgt_base_i,
    input  logic [addr_width-1:0] psum_base_i,
    input  logic [cnt_w-1:0]      n_act_i,
    input  logic [cnt_w-1:0]      n_wgt_i,
    input  logic [cnt_w-1:0]      n_psum_i,
    input  logic                  l0_afull_i,
    input  logic                  ififo_afull_i,
    input  logic                  ofifo_valid_i,
    input  logic                  ofifo_full_i,
    output logic                  sram_en_o,
    output logic                  sram_wen_o,
    output logic [addr_width-1:0] sram_addr_o,
    output logic                  l0_wr_o,
    output logic                  ififo_wr_o,
    output logic                  ofifo_rd_o,
    output logic [1:0]            grant_o,
    output logic                  busy_o,
    output logic                  done_o
);

    state_e                r_state;
    req_e                  r_cur;
    logic [addr_width-1:0] r_ptr [NUM_REQ];
    logic [cnt_w-1:0]      r_rem [NUM_REQ];

    logic [NUM_REQ-1:0]    w_elig;
    logic [NUM_REQ-1:0]    w_iss_oh;
    req_e                  w_grant;
    req_e                  w_issue;
    logic                  w_cont;
    logic                  w_all_zero;
    logic [addr_width-1:0] w_addr;

    assign w_elig[0]  = (r_rem[0] != '0) && !l0_afull_i;
    assign w_elig[1]  = (r_rem[1] != '0) && !ififo_afull_i;
    assign w_elig[2]  = (r_rem[2] != '0) && ofifo_valid_i;
    assign w_all_zero = (r_rem[0] == '0) && (r_rem[1] == '0) && (r_rem[2] == '0);

    // In BURST the current owner keeps the port; in ARB the arbiter's pick issues.
    assign w_issue  = (r_state == ST_BURST && w_cont) ? r_cur : w_grant;
    assign w_iss_oh = req_to_oh(w_issue);

    always_comb begin
        w_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_iss_oh[i]) w_addr = r_ptr[i];
        end
    end

    os_sram_port_sched_arb #(
        .burst_len (burst_len)
    ) u_arb (
        .clk          (clk),
        .reset        (reset),
        .i_elig       (w_elig),
        .i_ofifo_full (ofifo_full_i),
        .i_arb        (r_state == ST_ARB),
        .i_burst      (r_state == ST_BURST),
        .i_cur        (r_cur),
        .o_grant      (w_grant),
        .o_cont       (w_cont)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cur       <= REQ_NONE;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_ptr[i] <= '0;
                r_rem[i] <= '0;
            end
            sram_en_o   <= 1'b0;
            sram_wen_o  <= 1'b0;
            sram_addr_o <= '0;
            l0_wr_o     <= 1'b0;
            ififo_wr_o  <= 1'b0;
            ofifo_rd_o  <= 1'b0;
            grant_o     <= REQ_NONE;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            sram_en_o  <= 1'b0;
            sram_wen_o <= 1'b0;
            ofifo_rd_o <= 1'b0;
            grant_o    <= REQ_NONE;
            done_o     <= 1'b0;
            // Read data returns one cycle after the strobe; push it then.
            l0_wr_o    <= sram_en_o && (grant_o == REQ_L0);
            ififo_wr_o <= sram_en_o && (grant_o == REQ_IFIFO);

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_state <= ST_IDLE;
                    if (start_i) begin
                        r_ptr[0] <= act_base_i;
                        r_ptr[1] <= wgt_base_i;
                        r_ptr[2] <= psum_base_i;
                        r_rem[0] <= n_act_i;
                        r_rem[1] <= n_wgt_i;
                        r_rem[2] <= n_psum_i;
                        busy_o   <= 1'b1;
                        r_state  <= ST_ARB;
                    end
                end
                ST_ARB, ST_BURST: begin
                    if (w_issue != REQ_NONE) begin
                        sram_en_o   <= 1'b1;
                        sram_wen_o  <= (w_issue == REQ_OFIFO);
                        ofifo_rd_o  <= (w_issue == REQ_OFIFO);
                        sram_addr_o <= w_addr;
                        grant_o     <= w_issue;
                        r_cur       <= w_issue;
                        r_state     <= ST_BURST;
                        for (int i = 0; i < NUM_REQ; i++) begin
                            if (w_iss_oh[i]) begin
                                r_ptr[i] <= r_ptr[i] + addr_width'(1);
                                r_rem[i] <= r_rem[i] - cnt_w'(1);
                            end
                        end
                    end else if (r_state == ST_BURST) begin
                        r_state <= ST_ARB;
                    end else if (w_all_zero) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_DONE;
                    busy_o  <= 1'b0;
                    done_o  <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_os_sram_port_sched.sv
// Directed and randomized bench for os_sram_port_sched against a burst-level
// schedule model of the arbitration rules.
module tb_os_sram_port_sched;

    localparam int AW = 11;
    localparam int CW = 11;
    localparam int BL = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_i;
    logic [AW-1:0] act_base_i, wgt_base_i, psum_base_i;
    logic [CW-1:0] n_act_i, n_wgt_i, n_psum_i;
    logic          l0_afull_i, ififo_afull_i, ofifo_valid_i, ofifo_full_i;
    logic          sram_en_o, sram_wen_o, l0_wr_o, ififo_wr_o, ofifo_rd_o, busy_o, done_o;
    logic [AW-1:0] sram_addr_o;
    logic [1:0]    grant_o;

    always #5 clk = ~clk;

    os_sram_port_sched #(.addr_width(AW), .cnt_w(CW), .burst_len(BL)) dut (
        .clk(clk), .reset(reset), .start_i(start_i),
        .act_base_i(act_base_i), .wgt_base_i(wgt_base_i), .psum_base_i(psum_base_i),
        .n_act_i(n_act_i), .n_wgt_i(n_wgt_i), .n_psum_i(n_psum_i),
        .l0_afull_i(l0_afull_i), .ififo_afull_i(ififo_afull_i),
        .ofifo_valid_i(ofifo_valid_i), .ofifo_full_i(ofifo_full_i),
        .sram_en_o(sram_en_o), .sram_wen_o(sram_wen_o), .sram_addr_o(sram_addr_o),
        .l0_wr_o(l0_wr_o), .ififo_wr_o(ififo_wr_o), .ofifo_rd_o(ofifo_rd_o),
        .grant_o(grant_o), .busy_o(busy_o), .done_o(done_o)
    );

    int n_chk = 0;
    int n_err = 0;

    // Expected per-cycle trace of one tile, starting the cycle after start_i.
    bit q_en[$];
    int q_req[$];
    int q_addr[$];
    bit q_busy[$];
    bit q_done[$];
    int m_last = 2;   // index of last grantee: 0 L0, 1 IFIFO, 2 OFIFO

    int l0_cnt, l0_base;
    bit done_seen, seen_if;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tstep();
        step();
        if (sram_en_o && grant_o == 2'd1) begin
            chk("l0_addr", sram_addr_o, (l0_base + l0_cnt) % 2048);
            l0_cnt++;
        end
        if (sram_en_o && grant_o == 2'd2) seen_if = 1'b1;
        if (done_o) done_seen = 1'b1;
    endtask

    task automatic chk_idle(input string pfx);
        chk({pfx, "_en"}, sram_en_o, 0);
        chk({pfx, "_wen"}, sram_wen_o, 0);
        chk({pfx, "_addr"}, sram_addr_o, 0);
        chk({pfx, "_l0wr"}, l0_wr_o, 0);
        chk({pfx, "_ififowr"}, ififo_wr_o, 0);
        chk({pfx, "_ofiford"}, ofifo_rd_o, 0);
        chk({pfx, "_grant"}, grant_o, 0);
        chk({pfx, "_busy"}, busy_o, 0);
        chk({pfx, "_done"}, done_o, 0);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        start_i = 1'b0;
        step();
        step();
        reset   = 1'b0;
        m_last  = 2;
    endtask

    task automatic push(input bit en, input int rq, input int ad, input bit bz, input bit dn);
        q_en.push_back(en);
        q_req.push_back(rq);
        q_addr.push_back(ad);
        q_busy.push_back(bz);
        q_done.push_back(dn);
    endtask

    // Burst-level plan: pick requesters by rule, emit min(BL, remaining) accesses, one idle cycle between grants.
    task automatic plan_tile(input int ab, input int wb, input int pb,
                             input int na, input int nw, input int np, input bit full);
        int rem[3];
        int nxt[3];
        int pick;
        int n;
        q_en.delete(); q_req.delete(); q_addr.delete(); q_busy.delete(); q_done.delete();
        rem = '{na, nw, np};
        nxt = '{ab, wb, pb};
        push(0, 0, 0, 1, 0);
        forever begin
            pick = -1;
            if (full && rem[2] > 0) pick = 2;
            else begin
                for (int k = 1; k <= 3; k++)
                    if (pick < 0 && rem[(m_last + k) % 3] > 0) pick = (m_last + k) % 3;
            end
            if (pick < 0) break;
            m_last = pick;
            n = (rem[pick] > BL) ? BL : rem[pick];
            for (int a = 0; a < n; a++) begin
                push(1, pick + 1, nxt[pick], 1, 0);
                nxt[pick] = (nxt[pick] + 1) % 2048;
                rem[pick]--;
            end
            push(0, 0, 0, 1, 0);
        end
        push(0, 0, 0, 1, 0);
        push(0, 0, 0, 0, 1);
    endtask

    task automatic run_tile(input int ab, input int wb, input int pb,
                            input int na, input int nw, input int np, input bit full, input bit noise);
        bit prev_l0, prev_if;
        plan_tile(ab, wb, pb, na, nw, np, full);
        act_base_i = AW'(ab); wgt_base_i = AW'(wb); psum_base_i = AW'(pb);
        n_act_i = CW'(na); n_wgt_i = CW'(nw); n_psum_i = CW'(np);
        ofifo_full_i = full; l0_afull_i = 0; ififo_afull_i = 0; ofifo_valid_i = 1;
        start_i = 1'b1;
        prev_l0 = 0;
        prev_if = 0;
        for (int j = 0; j < q_en.size(); j++) begin
            step();
            start_i = 1'b0;
            if (noise && q_busy[j]) begin
                start_i    = 1'($urandom_range(0, 1));
                act_base_i = AW'($urandom);
                n_act_i    = CW'($urandom);
                n_psum_i   = CW'($urandom);
            end
            chk("en", sram_en_o, q_en[j]);
            chk("wen", sram_wen_o, q_en[j] && q_req[j] == 3);
            chk("ofifo_rd", ofifo_rd_o, q_en[j] && q_req[j] == 3);
            chk("grant", grant_o, q_en[j] ? q_req[j] : 0);
            if (q_en[j]) chk("addr", sram_addr_o, q_addr[j]);
            chk("l0_wr", l0_wr_o, prev_l0);
            chk("ififo_wr", ififo_wr_o, prev_if);
            chk("busy", busy_o, q_busy[j]);
            chk("done", done_o, q_done[j]);
            prev_l0 = q_en[j] && q_req[j] == 1;
            prev_if = q_en[j] && q_req[j] == 2;
        end
        start_i = 1'b0;
        step();
        chk("post_busy", busy_o, 0);
        chk("post_done", done_o, 0);
        chk("post_en", sram_en_o, 0);
    endtask

    initial begin
        int c0;
        int guard;
        reset = 1'b1; start_i = 0;
        act_base_i = 0; wgt_base_i = 0; psum_base_i = 0;
        n_act_i = 0; n_wgt_i = 0; n_psum_i = 0;
        l0_afull_i = 0; ififo_afull_i = 0; ofifo_valid_i = 0; ofifo_full_i = 0;
        step();
        step();
        chk_idle("rst");
        reset = 1'b0;
        step();
        step();
        chk_idle("idle");

        // All counts zero: done three cycles after start, no access.
        run_tile(0, 0, 0, 0, 0, 0, 0, 0);
        // Equal 20/20/20 tile: rotating bursts of 8.
        run_tile(12'h000, 12'h100, 12'h200, 20, 20, 20, 0, 0);
        // Activation reads wrapping around the top of the address space.
        run_tile(12'h7FE, 0, 0, 5, 0, 0, 0, 0);

        for (int t = 0; t < 6; t++)
            run_tile($urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047),
                     $urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 20),
                     1'($urandom_range(0, 1)), 1'b1);

        // OFIFO full raised mid L0 burst: L0 completes, OFIFO gets the next grant.
        do_reset();
        l0_cnt = 0; l0_base = 0; done_seen = 0; seen_if = 0;
        act_base_i = 0; wgt_base_i = 11'h100; psum_base_i = 11'h200;
        n_act_i = 20; n_wgt_i = 20; n_psum_i = 20;
        ofifo_full_i = 0; ofifo_valid_i = 1; l0_afull_i = 0; ififo_afull_i = 0;
        start_i = 1;
        tstep();
        start_i = 0;
        guard = 0;
        while (grant_o != 2'd1 && guard < 10) begin tstep(); guard++; end
        c0 = 0;
        guard = 0;
        while (grant_o == 2'd1 && guard < 30) begin
            c0++;
            if (c0 == 3) ofifo_full_i = 1;
            tstep();
            guard++;
        end
        chk("full_l0_burst", c0, 8);
        chk("full_gap", grant_o, 0);
        tstep();
        chk("full_next_grant", grant_o, 3);
        ofifo_full_i = 0;
        guard = 0;
        while (!done_seen && guard < 300) begin tstep(); guard++; end
        chk("full_done", done_seen, 1);
        chk("full_l0_total", l0_cnt, 20);

        // L0 almost-full mid burst: stop L0, rotate to IFIFO, resume later.
        do_reset();
        l0_cnt = 0; l0_base = 11'h010; done_seen = 0; seen_if = 0;
        act_base_i = 11'h010; wgt_base_i = 11'h300; psum_base_i = 0;
        n_act_i = 20; n_wgt_i = 4; n_psum_i = 0;
        start_i = 1;
        tstep();
        start_i = 0;
        guard = 0;
        while (l0_cnt < 3 && guard < 20) begin tstep(); guard++; end
        l0_afull_i = 1;
        c0 = l0_cnt;
        for (int k = 0; k < 4; k++) tstep();
        chk("afull_extra", (l0_cnt - c0) <= 1, 1);
        guard = 0;
        while (!seen_if && guard < 10) begin tstep(); guard++; end
        chk("afull_rotate", seen_if, 1);
        c0 = l0_cnt;
        for (int k = 0; k < 4; k++) tstep();
        chk("afull_hold", l0_cnt, c0);
        l0_afull_i = 0;
        guard = 0;
        while (!done_seen && guard < 200) begin tstep(); guard++; end
        chk("afull_done", done_seen, 1);
        chk("afull_l0_total", l0_cnt, 20);

        // Reset in the middle of a burst, then a clean tile.
        l0_cnt = 0; l0_base = 0;
        act_base_i = 0; n_act_i = 20; n_wgt_i = 20; n_psum_i = 20;
        start_i = 1;
        tstep();
        start_i = 0;
        guard = 0;
        while (!sram_en_o && guard < 10) begin tstep(); guard++; end
        chk("mid_en_seen", sram_en_o, 1);
        tstep();
        tstep();
        reset = 1;
        step();
        chk_idle("midrst");
        reset = 0;
        m_last = 2;
        run_tile(11'h020, 11'h040, 11'h060, 3, 2, 10, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
